// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared receiver state type and 640x480 reference timing
package vga_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } rx_state_t;

   localparam int H_TOTAL_640  = 800;
   localparam int H_ACTIVE_640 = 640;
   localparam int H_SYNC_640   = 96;
   localparam int V_TOTAL_640  = 525;
   localparam int V_ACTIVE_640 = 480;

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - pix_en-qualified rise/fall detector against the previous sample
module vga_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pix_en_i,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= RESET_VAL;
      end else if (pix_en_i) begin
         prev_q <= sig_i;
      end
   end

   assign rise_o = pix_en_i & sig_i & ~prev_q;
   assign fall_o = pix_en_i & ~sig_i & prev_q;

endmodule

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - video timing receiver: measures sync/DE timing, locks, recovers pixel position
module vga_sync_rx
   import vga_pkg::*;
#(
   parameter int HPOS_WIDTH  = 10,
   parameter int VPOS_WIDTH  = 10,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_en,
   input  logic                  hsync_n,
   input  logic                  vsync_n,
   input  logic                  de,
   output logic [HPOS_WIDTH-1:0] hpos,
   output logic [VPOS_WIDTH-1:0] vpos,
   output logic                  de_out,
   output logic [HPOS_WIDTH-1:0] h_total,
   output logic [HPOS_WIDTH-1:0] h_active,
   output logic [HPOS_WIDTH-1:0] h_sync,
   output logic [VPOS_WIDTH-1:0] v_total,
   output logic [VPOS_WIDTH-1:0] v_active,
   output logic                  locked,
   output logic                  frame_start,
   output logic                  err
);

   localparam int HW = HPOS_WIDTH;
   localparam int VW = VPOS_WIDTH;
   localparam int FW = 3 * HW + 2 * VW;
   localparam logic [HW-1:0] H_MAX = '1;
   localparam logic [VW-1:0] V_MAX = '1;

   function automatic logic [HW-1:0] h_inc(input logic [HW-1:0] v);
      return (v == H_MAX) ? v : v + HW'(1);
   endfunction

   function automatic logic [VW-1:0] v_inc(input logic [VW-1:0] v);
      return (v == V_MAX) ? v : v + VW'(1);
   endfunction

   logic h_rise, h_fall, v_fall, v_rise_unused, de_rise, de_fall;

   vga_sync_edge #(.RESET_VAL(1'b1)) u_hs_edge (
      .clk(clk), .rst(rst), .pix_en_i(pix_en), .sig_i(hsync_n), .rise_o(h_rise), .fall_o(h_fall));
   vga_sync_edge #(.RESET_VAL(1'b1)) u_vs_edge (
      .clk(clk), .rst(rst), .pix_en_i(pix_en), .sig_i(vsync_n), .rise_o(v_rise_unused), .fall_o(v_fall));
   vga_sync_edge #(.RESET_VAL(1'b0)) u_de_edge (
      .clk(clk), .rst(rst), .pix_en_i(pix_en), .sig_i(de), .rise_o(de_rise), .fall_o(de_fall));

   rx_state_t     state_q;
   logic [3:0]    match_cnt_q, match_nx;
   logic          ref_valid_q, de_out_q, frame_start_q, err_q;
   logic [HW-1:0] line_cnt_q, line_cnt_d, hs_cnt_q, hs_cnt_d, de_cnt_q, de_cnt_d, hpos_q, hpos_d;
   logic [HW-1:0] cur_htot_q, cur_hsync_q, cur_hact_q;
   logic [VW-1:0] v_cnt_q, v_cnt_d, vde_cnt_q, vde_cnt_d, vpos_q, vpos_d;
   logic [FW-1:0] ref_q, lock_q, frame_vec;
   logic          timeout, line_bad, sync_bad, frame_ok;

   always_comb begin
      line_cnt_d = line_cnt_q;
      hs_cnt_d   = hs_cnt_q;
      de_cnt_d   = de_cnt_q;
      hpos_d     = hpos_q;
      v_cnt_d    = v_cnt_q;
      vde_cnt_d  = vde_cnt_q;
      vpos_d     = vpos_q;
      if (pix_en) begin
         line_cnt_d = h_fall ? HW'(1) : h_inc(line_cnt_q);
         if (v_fall && state_q == SEARCH) line_cnt_d = h_fall ? HW'(1) : '0;
         if (!hsync_n) hs_cnt_d = h_fall ? HW'(1) : h_inc(hs_cnt_q);
         if (de) de_cnt_d = de_rise ? HW'(1) : h_inc(de_cnt_q);
         hpos_d = de_rise ? '0 : h_inc(hpos_q);
      end
      if (v_fall) v_cnt_d = '0;
      else if (h_fall) v_cnt_d = v_inc(v_cnt_q);
      if (v_fall) vde_cnt_d = '0;
      else if (de_rise) vde_cnt_d = v_inc(vde_cnt_q);
      if (de_rise) vpos_d = vde_cnt_q;
      // A line ending on the same sample as vsync belongs to the frame that is closing
      frame_vec = {h_fall ? line_cnt_q : cur_htot_q,
                   de_fall ? de_cnt_q : cur_hact_q,
                   h_rise ? hs_cnt_q : cur_hsync_q,
                   h_fall ? v_inc(v_cnt_q) : v_cnt_q,
                   vde_cnt_q};
   end

   assign {h_total, h_active, h_sync, v_total, v_active} = lock_q;

   assign match_nx = match_cnt_q + 4'd1;
   assign timeout  = pix_en && (line_cnt_q == H_MAX);
   assign line_bad = h_fall && (line_cnt_q != h_total);
   assign sync_bad = h_rise && (hs_cnt_q != h_sync);
   assign frame_ok = !ref_valid_q || (frame_vec == ref_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_cnt_q    <= '0;
         hs_cnt_q      <= '0;
         de_cnt_q      <= '0;
         hpos_q        <= '0;
         v_cnt_q       <= '0;
         vde_cnt_q     <= '0;
         vpos_q        <= '0;
         cur_htot_q    <= '0;
         cur_hsync_q   <= '0;
         cur_hact_q    <= '0;
         de_out_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         line_cnt_q    <= line_cnt_d;
         hs_cnt_q      <= hs_cnt_d;
         de_cnt_q      <= de_cnt_d;
         hpos_q        <= hpos_d;
         v_cnt_q       <= v_cnt_d;
         vde_cnt_q     <= vde_cnt_d;
         vpos_q        <= vpos_d;
         frame_start_q <= v_fall;
         if (pix_en) de_out_q <= de;
         if (h_fall) cur_htot_q <= line_cnt_q;
         if (h_rise) cur_hsync_q <= hs_cnt_q;
         if (de_fall) cur_hact_q <= de_cnt_q;
      end
   end

   // The first frame measured after SEARCH has nothing to compare against and seeds the reference
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SEARCH;
         match_cnt_q <= '0;
         ref_valid_q <= 1'b0;
         ref_q       <= '0;
         lock_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (pix_en) begin
            case (state_q)
               SEARCH: begin
                  if (v_fall) begin
                     state_q     <= MEASURE;
                     match_cnt_q <= '0;
                     ref_valid_q <= 1'b0;
                  end
               end
               MEASURE: begin
                  if (timeout) begin
                     state_q <= SEARCH;
                  end else if (v_fall) begin
                     ref_q       <= frame_vec;
                     ref_valid_q <= 1'b1;
                     if (frame_ok) begin
                        match_cnt_q <= match_nx;
                        if (match_nx >= 4'(LOCK_FRAMES)) begin
                           state_q <= LOCKED;
                           lock_q  <= frame_vec;
                        end
                     end else begin
                        match_cnt_q <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (timeout || line_bad || sync_bad || (v_fall && frame_vec != lock_q)) begin
                     err_q   <= 1'b1;
                     state_q <= SEARCH;
                  end
               end
               default: state_q <= SEARCH;
            endcase
         end
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign de_out      = de_out_q;
   assign locked      = (state_q == LOCKED);
   assign frame_start = frame_start_q;
   assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb/tb_vga_sync_rx.sv - directed bench for vga_sync_rx using a reduced 40x12 timing
module tb_vga_sync_rx;

   localparam int HT = 40;
   localparam int HS = 6;
   localparam int HA0 = 12;
   localparam int HA1 = 36;
   localparam int VS = 2;
   localparam int VA0 = 3;
   localparam int VA1 = 11;

   logic       clk = 1'b0;
   logic       rst, pix_en, hsync_n, vsync_n, de;
   logic [9:0] hpos, vpos, h_total, h_active, h_sync, v_total, v_active;
   logic       de_out, locked, frame_start, err;

   vga_sync_rx #(.HPOS_WIDTH(10), .VPOS_WIDTH(10), .LOCK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de),
      .hpos(hpos), .vpos(vpos), .de_out(de_out),
      .h_total(h_total), .h_active(h_active), .h_sync(h_sync),
      .v_total(v_total), .v_active(v_active),
      .locked(locked), .frame_start(frame_start), .err(err));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fs_cnt = 0;
   int err_cnt = 0;
   int lock_cycles = 0;
   logic lock_at_fs [0:63];

   always @(negedge clk) begin
      if (frame_start) begin
         if (fs_cnt < 64) lock_at_fs[fs_cnt] = locked;
         fs_cnt = fs_cnt + 1;
      end
      if (err) err_cnt = err_cnt + 1;
      if (locked) lock_cycles = lock_cycles + 1;
   end

   logic [9:0] snap_hpos, snap_vpos;
   logic       snap_de;
   logic [20:0] p0, p1;
   logic        pre_de, post_de;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_pos"}, {43'd0, hpos, vpos, de_out}, 64'd0);
      chk({tag, "_meas"}, {14'd0, h_total, h_active, h_sync, v_total, v_active}, 64'd0);
      chk({tag, "_flags"}, {61'd0, locked, frame_start, err}, 64'd0);
   endtask

   // One sample per four clocks; outputs are snapshotted one clock after the sampling edge
   task automatic pix(input logic hs, input logic vs, input logic d);
      @(negedge clk);
      hsync_n = hs;
      vsync_n = vs;
      de      = d;
      pix_en  = 1'b1;
      @(negedge clk);
      pix_en    = 1'b0;
      snap_hpos = hpos;
      snap_vpos = vpos;
      snap_de   = de_out;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic frame(input int vtot, input int stretch, input int l_from, input int l_to);
      int   n;
      logic act;
      for (int l = l_from; l <= l_to && l < vtot; l++) begin
         n = (l == stretch) ? HT + 1 : HT;
         for (int s = 0; s < n; s++) begin
            act = (l >= VA0) && (l < VA1) && (s >= HA0) && (s < HA1);
            pix((s < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, act);
            if (l == VA0 && s == HA0 - 1) pre_de = snap_de;
            if (l == VA0 && s == HA0) p0 = {snap_hpos, snap_vpos, snap_de};
            if (l == VA1 - 1 && s == HA1 - 1) p1 = {snap_hpos, snap_vpos, snap_de};
            if (l == VA1 - 1 && s == HA1) post_de = snap_de;
         end
      end
   endtask

   initial begin
      int err_base, lc_base, fs_base;
      rst = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; de = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      frame(12, -1, 0, 11);
      frame(12, -1, 0, 11);
      chk("no_lock_after_2", {63'd0, locked}, 64'd0);
      frame(12, -1, 0, 11);
      chk("fs_count_3", fs_cnt, 3);
      chk("lock_at_fs2", {63'd0, lock_at_fs[1]}, 64'd0);
      chk("lock_at_fs3", {63'd0, lock_at_fs[2]}, 64'd1);
      chk("h_total", h_total, 40);
      chk("h_active", h_active, 24);
      chk("h_sync", h_sync, 6);
      chk("v_total", v_total, 12);
      chk("v_active", v_active, 8);
      chk("pix_first", p0, {10'd0, 10'd0, 1'b1});
      chk("pix_last", p1, {10'd23, 10'd7, 1'b1});
      chk("de_before_first", {63'd0, pre_de}, 64'd0);
      chk("de_after_last", {63'd0, post_de}, 64'd0);

      frame(12, 5, 0, 11);
      chk("stretch_err", err_cnt, 1);
      chk("stretch_unlock", {63'd0, locked}, 64'd0);
      frame(12, -1, 0, 11);
      frame(12, -1, 0, 11);
      chk("stretch_still_unlocked", {63'd0, locked}, 64'd0);
      frame(12, -1, 0, 11);
      chk("stretch_relock", {63'd0, locked}, 64'd1);
      chk("stretch_err_once", err_cnt, 1);

      repeat (1100) pix(1'b1, 1'b1, 1'b0);
      chk("timeout_err", err_cnt, 2);
      chk("timeout_unlock", {63'd0, locked}, 64'd0);
      chk("timeout_hpos_sat", hpos, 1023);

      repeat (3) frame(12, -1, 0, 11);
      chk("relock_after_timeout", {63'd0, locked}, 64'd1);

      frame(12, -1, 0, 4);
      for (int s = 0; s <= 20; s++) pix((s < HS) ? 1'b0 : 1'b1, 1'b1, (s >= HA0) ? 1'b1 : 1'b0);
      chk("pre_rst_state", {locked, de_out, hpos}, {1'b1, 1'b1, 10'd8});
      rst = 1'b1;
      #1;
      check_all_zero("midframe_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int s = 21; s < HT; s++) pix(1'b1, 1'b1, (s < HA1) ? 1'b1 : 1'b0);
      frame(12, -1, 6, 11);
      frame(12, -1, 0, 11);
      frame(12, -1, 0, 11);
      chk("rst_no_lock_2_falls", {63'd0, locked}, 64'd0);
      chk("rst_meas_cleared", h_total, 0);
      frame(12, -1, 0, 11);
      chk("rst_relock_3_falls", {63'd0, locked}, 64'd1);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      err_base = err_cnt;
      lc_base  = lock_cycles;
      fs_base  = fs_cnt;
      repeat (3) begin
         frame(12, -1, 0, 11);
         frame(13, -1, 0, 12);
      end
      chk("alt_never_locked", lock_cycles - lc_base, 0);
      chk("alt_no_err", err_cnt - err_base, 0);
      chk("alt_frame_starts", fs_cnt - fs_base, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
